// File: rtl/enc_bundler.sv
// Purpose: accumulate per-bit set counts of NUM_IN bound HVs over NUM_GROUPS beats, then threshold them to one sample HV.
// Latency: last beat accepted at edge E, sample_hv/out_valid valid in the cycle after edge E+1 (one-cycle out_valid pulse).
// Backpressure: in_ready is high only while accumulating; in_valid low stalls with no timeout; output has no ready (pulse only).
module enc_bundler #(
    parameter int HV_DIM     = 1024,
    parameter int NUM_IN     = 10,
    parameter int NUM_GROUPS = 16,
    parameter int CNT_W      = 8,
    parameter int THRESHOLD  = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start_bundling,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [HV_DIM-1:0] shifted_hv [0:NUM_IN-1],
    output logic [HV_DIM-1:0] sample_hv,
    output logic              out_valid,
    output logic              busy
);

    localparam int PC_W   = $clog2(NUM_IN + 1);
    localparam int SUM_W  = CNT_W + PC_W;
    localparam int BEAT_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_GROUPS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_THRESH,
        S_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [BEAT_W-1:0]             beat_cnt_q, beat_cnt_d;
    logic [HV_DIM-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [HV_DIM-1:0]             sample_hv_q, sample_hv_d;
    logic                          in_ready_q, in_ready_d;
    logic                          out_valid_q, out_valid_d;
    logic                          busy_q, busy_d;

    logic                          clr_cnt;
    logic                          acc_beat;
    logic [HV_DIM-1:0][PC_W-1:0]   pc;
    logic [HV_DIM-1:0][SUM_W-1:0]  sum;
    logic [HV_DIM-1:0]             thr_hv;

    // Sequencing: start a sample, collect beats, threshold once, pulse done.
    always_comb begin
        state_d  = state_q;
        clr_cnt  = 1'b0;
        acc_beat = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_bundling) begin
                    state_d = S_ACCUM;
                    clr_cnt = 1'b1;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    acc_beat = 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = S_THRESH;
                    end
                end
            end
            S_THRESH: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (start_bundling) begin
                    state_d = S_ACCUM;
                    clr_cnt = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Column popcount: how many of the NUM_IN HVs have bit b set this beat.
    always_comb begin
        pc = '0;
        for (int b = 0; b < HV_DIM; b++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                pc[b] = pc[b] + PC_W'(shifted_hv[i][b]);
            end
        end
    end

    // Per-bit counter update: clear on a new sample, saturating add on an accepted beat.
    always_comb begin
        cnt_d = cnt_q;
        sum   = '0;
        for (int b = 0; b < HV_DIM; b++) begin
            sum[b] = SUM_W'(cnt_q[b]) + SUM_W'(pc[b]);
            if (clr_cnt) begin
                cnt_d[b] = '0;
            end else if (acc_beat) begin
                if (sum[b] > SUM_W'(CNT_MAX)) begin
                    cnt_d[b] = CNT_MAX;
                end else begin
                    cnt_d[b] = sum[b][CNT_W-1:0];
                end
            end
        end
    end

    // Threshold the finished counts; sample_hv only changes on the THRESH edge.
    always_comb begin
        thr_hv = '0;
        for (int b = 0; b < HV_DIM; b++) begin
            thr_hv[b] = (32'(cnt_q[b]) >= 32'(THRESHOLD));
        end
        sample_hv_d = (state_q == S_THRESH) ? thr_hv : sample_hv_q;
    end

    // Beat counter and registered status decodes of the next state.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (clr_cnt) begin
            beat_cnt_d = '0;
        end else if (acc_beat) begin
            beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;
        end
        in_ready_d  = (state_d == S_ACCUM);
        busy_d      = (state_d == S_ACCUM) || (state_d == S_THRESH);
        out_valid_d = (state_d == S_DONE);
    end

    // State registers; synchronous reset aborts any sample in progress.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= '0;
            cnt_q       <= '0;
            sample_hv_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            cnt_q       <= cnt_d;
            sample_hv_q <= sample_hv_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sample_hv = sample_hv_q;

endmodule

// File: tb/tb_enc_bundler.sv
// Purpose: randomized and directed checks of enc_bundler against an arithmetic per-bit count model.
// Latency: expects out_valid/sample_hv two edges after the last accepted beat.
// Backpressure: drives random in_valid stalls; out_valid has no ready.
module tb_enc_bundler;

    localparam int HV    = 16;
    localparam int NI    = 10;
    localparam int NG    = 2;
    localparam int THR_A = 3;
    localparam int THR_B = 15;
    localparam int CW_A  = 8;
    localparam int CW_B  = 4;

    logic          clk = 1'b0;
    logic          nrst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [HV-1:0] hv [0:NI-1];
    logic          in_ready_a, out_valid_a, busy_a;
    logic          in_ready_b, out_valid_b, busy_b;
    logic [HV-1:0] sample_a, sample_b;

    int            checks = 0;
    int            errors = 0;
    logic [HV-1:0] beats [0:NG-1][0:NI-1];
    logic [HV-1:0] prev_a = '0;
    logic [HV-1:0] prev_b = '0;
    int            raw [0:HV-1];

    always #5 clk = ~clk;

    // Main instance with the default-like counter width.
    enc_bundler #(.HV_DIM(HV), .NUM_IN(NI), .NUM_GROUPS(NG), .CNT_W(CW_A), .THRESHOLD(THR_A)) u_dut_a (
        .clk(clk), .nrst(nrst), .start_bundling(start), .in_valid(in_valid), .in_ready(in_ready_a),
        .shifted_hv(hv), .sample_hv(sample_a), .out_valid(out_valid_a), .busy(busy_a)
    );

    // Narrow-counter instance: exposes wrap vs saturation (max count 20 > 15).
    enc_bundler #(.HV_DIM(HV), .NUM_IN(NI), .NUM_GROUPS(NG), .CNT_W(CW_B), .THRESHOLD(THR_B)) u_dut_b (
        .clk(clk), .nrst(nrst), .start_bundling(start), .in_valid(in_valid), .in_ready(in_ready_b),
        .shifted_hv(hv), .sample_hv(sample_b), .out_valid(out_valid_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [HV-1:0] rnd_hv(input int mode);
        logic [HV-1:0] v;
        case (mode)
            0:       v = HV'($urandom) & HV'($urandom);
            1:       v = HV'($urandom);
            2:       v = HV'($urandom) | HV'($urandom);
            default: v = HV'($urandom) | HV'($urandom) | HV'($urandom);
        endcase
        return v;
    endfunction

    task automatic rand_inputs();
        for (int i = 0; i < NI; i++) hv[i] = HV'($urandom);
    endtask

    // Issue start (optionally with a beat that must be dropped); ends in the first ACCUM cycle.
    task automatic start_sample(input bit junk_beat);
        start    = 1'b1;
        in_valid = junk_beat;
        rand_inputs();
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        for (int b = 0; b < HV; b++) raw[b] = 0;
        check("start_rdy", in_ready_a, 1);
        check("start_busy", busy_a, 1);
        check("start_ov", out_valid_a, 0);
        check("start_hold", sample_a, prev_a);
    endtask

    // Feed NG beats from 'beats' with smin..smax stall cycles before each beat.
    task automatic feed(input int smin, input int smax, input bit junk_start);
        for (int g = 0; g < NG; g++) begin
            int st;
            st = $urandom_range(smax, smin);
            for (int s = 0; s < st; s++) begin
                in_valid = 1'b0;
                start    = junk_start & 1'($urandom_range(1, 0));
                rand_inputs();
                @(negedge clk);
                check("stall_rdy", in_ready_a, 1);
                check("stall_ov", out_valid_a, 0);
                check("stall_hold", sample_a, prev_a);
            end
            in_valid = 1'b1;
            start    = junk_start & 1'($urandom_range(1, 0));
            for (int i = 0; i < NI; i++) begin
                hv[i] = beats[g][i];
                for (int b = 0; b < HV; b++) raw[b] += int'(beats[g][i][b]);
            end
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
        end
    endtask

    // Check the THRESH and DONE cycles; optionally leave the DONE cycle open for a back-to-back start.
    task automatic finish(input bit b2b);
        logic [HV-1:0] exp_a, exp_b;
        for (int b = 0; b < HV; b++) begin
            exp_a[b] = (((raw[b] > 255) ? 255 : raw[b]) >= THR_A);
            exp_b[b] = (((raw[b] > 15) ? 15 : raw[b]) >= THR_B);
        end
        check("thr_rdy", in_ready_a, 0);
        check("thr_busy", busy_a, 1);
        check("thr_ov", out_valid_a, 0);
        check("thr_hold", sample_a, prev_a);
        @(negedge clk);
        check("done_ov_a", out_valid_a, 1);
        check("done_ov_b", out_valid_b, 1);
        check("done_busy", busy_a, 0);
        check("done_rdy", in_ready_a, 0);
        check("done_hv_a", sample_a, exp_a);
        check("done_hv_b", sample_b, exp_b);
        prev_a = exp_a;
        prev_b = exp_b;
        if (!b2b) begin
            @(negedge clk);
            check("idle_ov", out_valid_a, 0);
            check("idle_busy", busy_a, 0);
            check("idle_hold", sample_a, prev_a);
        end
    endtask

    task automatic clear_beats();
        for (int g = 0; g < NG; g++)
            for (int i = 0; i < NI; i++) beats[g][i] = '0;
    endtask

    initial begin
        rand_inputs();
        repeat (2) @(negedge clk);
        check("rst_rdy", in_ready_a, 0);
        check("rst_ov", out_valid_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_hv", sample_a, 0);
        nrst = 1'b0;
        @(negedge clk);

        // Directed: bit0 count 3, bit5 count 2 -> 0x0001.
        clear_beats();
        beats[0][0][0] = 1'b1;
        beats[0][1][0] = 1'b1;
        beats[1][2][0] = 1'b1;
        beats[1][3][5] = 1'b1;
        beats[1][4][5] = 1'b1;
        start_sample(1'b0);
        feed(0, 0, 1'b0);
        finish(1'b0);
        check("t1_const", sample_a, 16'h0001);

        // Same beats with 5-cycle stalls.
        start_sample(1'b0);
        feed(5, 5, 1'b0);
        finish(1'b0);
        check("t2_const", sample_a, 16'h0001);

        // All ones: narrow counters must saturate at 15, not wrap to 4.
        for (int g = 0; g < NG; g++)
            for (int i = 0; i < NI; i++) beats[g][i] = '1;
        start_sample(1'b0);
        feed(0, 1, 1'b0);
        finish(1'b0);
        check("t3_sat_b", sample_b, 16'hFFFF);
        check("t3_sat_a", sample_a, 16'hFFFF);

        // Reset after the first beat aborts the sample.
        start_sample(1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < NI; i++) hv[i] = '1;
        @(negedge clk);
        in_valid = 1'b0;
        nrst = 1'b1;
        @(negedge clk);
        nrst = 1'b0;
        check("mrst_rdy", in_ready_a, 0);
        check("mrst_busy", busy_a, 0);
        check("mrst_hv", sample_a, 0);
        prev_a = '0;
        prev_b = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("mrst_ov", out_valid_a, 0);
        end
        clear_beats();
        start_sample(1'b0);
        feed(0, 2, 1'b0);
        finish(1'b0);
        check("t4_zero", sample_a, 16'h0000);

        // Starts during ACCUM ignored; back-to-back start in DONE; junk beat with start.
        for (int g = 0; g < NG; g++)
            for (int i = 0; i < NI; i++) beats[g][i] = rnd_hv(1);
        start_sample(1'b0);
        feed(1, 3, 1'b1);
        finish(1'b1);
        for (int g = 0; g < NG; g++)
            for (int i = 0; i < NI; i++) beats[g][i] = rnd_hv(0);
        start_sample(1'b1);
        feed(0, 2, 1'b0);
        finish(1'b0);
        start_sample(1'b1);
        feed(0, 2, 1'b0);
        finish(1'b0);

        // Randomized samples.
        for (int n = 0; n < 40; n++) begin
            int mode;
            mode = $urandom_range(3, 0);
            for (int g = 0; g < NG; g++)
                for (int i = 0; i < NI; i++) beats[g][i] = rnd_hv(mode);
            start_sample(1'($urandom_range(1, 0)));
            feed(0, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
            finish(1'($urandom_range(1, 0)));
        end
        // Drain a possible pending DONE cycle without starting.
        @(negedge clk);
        check("end_ov", out_valid_a, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
